spy_block_loader: RTL and testbench
===================================

# spy_block_loader

Sequential writer that fills the spy memory from an external valid/ready word stream while the spy buffer is in `PLAYBACK_WRITE` mode. It writes words to consecutive addresses starting at 0 and drives `ram_write_enable`/`ram_write_addr`/`ram_write_data` into the spy memory write port. It reports `load_last_addr`, which the spy playback controller uses as its stop/wrap address. It is the writer counterpart of the playback reader and sits between the host-side stream and the spy memory.

## Interface
- `DATAWIDTH`, 64, payload width without the metadata bit; data buses are `DATAWIDTH+1` bits.
- `MEMWIDTH`, 6, spy memory address width; depth `D = 2**MEMWIDTH`.
- `clock`  in  1  single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `playback`  in  2  spy mode; encodings come from `SpyProtocol.vh` (`NO_PLAYBACK`, `PLAYBACK_ONCE`, `PLAYBACK_LOOP`, `PLAYBACK_WRITE`).
- `load_start`  in  1  one-cycle pulse that arms a new load.
- `s_valid`  in  1  stream word valid.
- `s_data`  in  DATAWIDTH+1  stream word.
- `s_last`  in  1  marks the final word of the block.
- `s_ready`  out  1  stream ready; combinational from state and `playback`.
- `ram_write_enable`  out  1  spy memory write strobe.
- `ram_write_addr`  out  MEMWIDTH  spy memory write address.
- `ram_write_data`  out  DATAWIDTH+1  spy memory write data.
- `load_last_addr`  out  MEMWIDTH  address of the last word written.
- `load_count`  out  MEMWIDTH+1  number of words written, 0..D.
- `busy`  out  1  high in `LOAD` or `DRAIN`.
- `load_done`  out  1  sticky; set when a load completes.
- `load_overflow`  out  1  sticky; set when the block exceeded `D` words.
- `load_abort`  out  1  sticky; set when `playback` left `PLAYBACK_WRITE` during a load.

## Operation
- States: `IDLE`, `LOAD`, `DRAIN`, `DONE`. Reset enters `IDLE`.
- Reset value of every output and flag is 0. `load_last_addr` resets to `D-1`, which is the playback controller's idle address.
- `IDLE`/`DONE` + `load_start` + `playback==PLAYBACK_WRITE`:
  - go to `LOAD`;
  - clear `load_count`, the write pointer, and all three sticky flags.
- `load_start` is ignored when `playback!=PLAYBACK_WRITE` or while `busy`.
- `s_ready = playback==PLAYBACK_WRITE && (state==LOAD || state==DRAIN)`.
- A beat is accepted when `s_valid && s_ready`.
- In `LOAD`, an accepted beat:
  - writes `s_data` at the write pointer `wp`;
  - sets `load_last_addr <= wp` and `wp <= wp+1`, with MEMWIDTH-bit wrap;
  - increments `load_count`.
- Leaving `LOAD`:
  - beat with `s_last` → `DONE`, and `load_done` is set;
  - beat that is word number `D` without `s_last` → `DRAIN`.
- `DRAIN`:
  - accepts and discards beats, with no RAM write;
  - on the first discarded beat, set `load_overflow`;
  - accepted beat with `s_last` → `DONE` and set `load_done`.
- `load_count` saturates at `D`; `load_last_addr` stays `D-1` after an overflow.
- Abort: if `playback!=PLAYBACK_WRITE` in `LOAD` or `DRAIN`, go to `IDLE` and set `load_abort`. No beat is accepted in that cycle.
- `DONE` holds every output until the next armed `load_start` or reset.
- A zero-word load is impossible, because a block needs at least one beat carrying `s_last`.

## Timing
- Write latency is 1 cycle: a beat accepted in cycle N produces `ram_write_enable=1` with the matching addr and data registered in cycle N+1.
- `ram_write_enable` is high for exactly one cycle per stored beat. It is low in all other cycles, including `DRAIN`.
- `load_count`, `load_last_addr` and `load_done` update in the same cycle N+1 as the write they describe.
- `s_ready` follows the state and `playback` with no registered delay:
  - first acceptable beat is in the cycle after `load_start`;
  - `s_ready` drops in the cycle after the `s_last` beat.
- Back-to-back beats are accepted every cycle, giving a throughput of 1 word/clock.
- Asynchronous `reset` mid-load clears state immediately:
  - no further write strobes, including any registered-but-unissued write;
  - no sticky flags set.

## Test plan
- Basic load, `MEMWIDTH=3` (`D=8`):
  - stimulus: `PLAYBACK_WRITE`, `load_start`, then 5 beats `0x10..0x14` back-to-back with `s_last` on the 5th;
  - response: writes at addrs 0..4, `load_count=5`, `load_last_addr=4`, `load_done=1`, `s_ready=0` afterwards.
- Exact fill:
  - stimulus: 8 beats with `s_last` on the 8th;
  - response: addrs 0..7 written, `load_count=8`, `load_last_addr=7`, `load_overflow=0`, `load_done=1`.
- Overflow:
  - stimulus: 11 beats with `s_last` on the 11th;
  - response: only 8 writes (addrs 0..7), beats 9–11 accepted with no write, `load_overflow=1`, `load_done=1`, `load_count=8`.
- Backpressure:
  - stimulus: `s_valid` toggled 1,0,1,0,1 with `s_last` on the 3rd valid beat;
  - response: exactly 3 writes at addrs 0..2, and no write in the cycles after an idle `s_valid` cycle.
- Abort:
  - stimulus: `playback` switched to `PLAYBACK_LOOP` after 2 beats, then a third beat driven;
  - response: third beat not accepted, state `IDLE`, `load_abort=1`, `load_done=0`, `load_count=2`.
- Reset mid-load:
  - stimulus: `reset` asserted on the same cycle a beat is accepted;
  - response: no `ram_write_enable`, all outputs 0, `load_last_addr=D-1`, `s_ready=0`.

Source files
------------

// File: rtl/spy_block_loader.sv
// Spy memory block loader: stores a valid/ready word stream at consecutive spy memory
// addresses, starting at 0, while the spy buffer is in write mode. It reports how many
// words landed and the address of the last one, which the playback controller uses as
// its stop/wrap point.
module spy_block_loader #(
  parameter int unsigned DATAWIDTH      = 64,
  parameter int unsigned MEMWIDTH       = 6,
  // Encoding of the write mode on the playback bus. The other modes (none, once, loop)
  // all look the same here: "not writing".
  parameter logic [1:0]  PLAYBACK_WRITE = 2'd3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           playback,
  input  logic                 load_start,
  input  logic                 s_valid,
  input  logic [DATAWIDTH:0]   s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 ram_write_enable,
  output logic [MEMWIDTH-1:0]  ram_write_addr,
  output logic [DATAWIDTH:0]   ram_write_data,
  output logic [MEMWIDTH-1:0]  load_last_addr,
  output logic [MEMWIDTH:0]    load_count,
  output logic                 busy,
  output logic                 load_done,
  output logic                 load_overflow,
  output logic                 load_abort
);

  localparam logic [MEMWIDTH-1:0] WpOne    = MEMWIDTH'(1);
  localparam logic [MEMWIDTH:0]   CntOne   = (MEMWIDTH + 1)'(1);
  // Top address; also what the playback controller treats as "idle" stop address.
  localparam logic [MEMWIDTH-1:0] AddrLast = {MEMWIDTH{1'b1}};

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } state_e;

  state_e                state_q, state_d;
  logic [MEMWIDTH-1:0]   wp_q, wp_d;
  logic [MEMWIDTH:0]     count_q, count_d;
  logic [MEMWIDTH-1:0]   last_addr_q, last_addr_d;
  logic                  done_q, done_d;
  logic                  overflow_q, overflow_d;
  logic                  abort_q, abort_d;
  logic                  we_q, we_d;
  logic [MEMWIDTH-1:0]   waddr_q, waddr_d;
  logic [DATAWIDTH:0]    wdata_q, wdata_d;

  logic write_mode;
  logic streaming;
  logic beat;
  logic arm;
  logic wp_at_top;

  // Stream handshake and arming qualifiers, all combinational from state and mode.
  always_comb begin
    write_mode = (playback == PLAYBACK_WRITE);
    streaming  = (state_q == StLoad) || (state_q == StDrain);
    beat       = s_valid && write_mode && streaming;
    arm        = load_start && write_mode && ((state_q == StIdle) || (state_q == StDone));
    // The beat taken with the pointer at the top address is word number D.
    wp_at_top  = (wp_q == AddrLast);
  end

  // Next-state logic for the load sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone: begin
        if (arm) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!write_mode) begin
          state_d = StIdle;
        end else if (beat) begin
          if (s_last) begin
            state_d = StDone;
          end else if (wp_at_top) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (!write_mode) begin
          state_d = StIdle;
        end else if (beat && s_last) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: write port, pointer, count and sticky status flags.
  always_comb begin
    wp_d        = wp_q;
    count_d     = count_q;
    last_addr_d = last_addr_q;
    done_d      = done_q;
    overflow_d  = overflow_q;
    abort_d     = abort_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;

    if (arm) begin
      wp_d       = '0;
      count_d    = '0;
      done_d     = 1'b0;
      overflow_d = 1'b0;
      abort_d    = 1'b0;
    end

    // Mode left write while a block was in flight; nothing is accepted this cycle.
    if (streaming && !write_mode) begin
      abort_d = 1'b1;
    end

    if (beat && (state_q == StLoad)) begin
      we_d        = 1'b1;
      waddr_d     = wp_q;
      wdata_d     = s_data;
      last_addr_d = wp_q;
      wp_d        = wp_q + WpOne;
      count_d     = count_q + CntOne;
    end

    // Beats past the memory depth are swallowed so the host stream can finish.
    if (beat && (state_q == StDrain)) begin
      overflow_d = 1'b1;
    end

    if (beat && s_last) begin
      done_d = 1'b1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; reset also kills any write registered but not yet issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp_q        <= '0;
      count_q     <= '0;
      last_addr_q <= AddrLast;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      abort_q     <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      wp_q        <= wp_d;
      count_q     <= count_d;
      last_addr_q <= last_addr_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      abort_q     <= abort_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Output mapping.
  always_comb begin
    s_ready          = write_mode && streaming;
    busy             = streaming;
    ram_write_enable = we_q;
    ram_write_addr   = waddr_q;
    ram_write_data   = wdata_q;
    load_last_addr   = last_addr_q;
    load_count       = count_q;
    load_done        = done_q;
    load_overflow    = overflow_q;
    load_abort       = abort_q;
  end

endmodule

// File: tb/tb_spy_block_loader.sv
// Bench for spy_block_loader with an 8-deep memory. A block-level model (beats seen,
// whether a block is open, sticky flags) predicts every output each cycle; directed
// literal checks after each scenario pin the model.
module tb_spy_block_loader;

  localparam int unsigned DW = 64;
  localparam int unsigned MW = 3;
  localparam int unsigned CW = DW + 1;
  localparam int          D  = 1 << MW;

  localparam logic [1:0] PB_LOOP  = 2'd2;
  localparam logic [1:0] PB_WRITE = 2'd3;

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic [1:0]    playback   = PB_WRITE;
  logic          load_start = 1'b0;
  logic          s_valid    = 1'b0;
  logic [DW:0]   s_data     = '0;
  logic          s_last     = 1'b0;
  logic          s_ready;
  logic          ram_write_enable;
  logic [MW-1:0] ram_write_addr;
  logic [DW:0]   ram_write_data;
  logic [MW-1:0] load_last_addr;
  logic [MW:0]   load_count;
  logic          busy;
  logic          load_done;
  logic          load_overflow;
  logic          load_abort;

  spy_block_loader #(
    .DATAWIDTH      (DW),
    .MEMWIDTH       (MW),
    .PLAYBACK_WRITE (PB_WRITE)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .playback         (playback),
    .load_start       (load_start),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_last           (s_last),
    .s_ready          (s_ready),
    .ram_write_enable (ram_write_enable),
    .ram_write_addr   (ram_write_addr),
    .ram_write_data   (ram_write_data),
    .load_last_addr   (load_last_addr),
    .load_count       (load_count),
    .busy             (busy),
    .load_done        (load_done),
    .load_overflow    (load_overflow),
    .load_abort       (load_abort)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Block-level model state.
  bit          m_open  = 1'b0;
  int          m_seen  = 0;
  bit          e_we    = 1'b0;
  int          e_addr  = 0;
  logic [DW:0] e_data  = '0;
  int          e_count = 0;
  int          e_last  = D - 1;
  bit          e_done  = 1'b0;
  bit          e_ovf   = 1'b0;
  bit          e_abort = 1'b0;

  // What the bench saw on the write port.
  logic [DW:0] mem [D];
  int          wr_count = 0;
  int          wr_base  = 0;

  task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    e_we = 1'b0;
    if (reset) begin
      m_open  = 1'b0;
      m_seen  = 0;
      e_count = 0;
      e_last  = D - 1;
      e_done  = 1'b0;
      e_ovf   = 1'b0;
      e_abort = 1'b0;
      e_addr  = 0;
      e_data  = '0;
    end else if (m_open) begin
      if (playback != PB_WRITE) begin
        m_open  = 1'b0;
        e_abort = 1'b1;
      end else if (s_valid) begin
        m_seen++;
        if (m_seen <= D) begin
          e_we    = 1'b1;
          e_addr  = m_seen - 1;
          e_data  = s_data;
          e_count = m_seen;
          e_last  = m_seen - 1;
        end else begin
          e_ovf = 1'b1;
        end
        if (s_last) begin
          m_open = 1'b0;
          e_done = 1'b1;
        end
      end
    end else if (load_start && playback == PB_WRITE) begin
      m_open  = 1'b1;
      m_seen  = 0;
      e_count = 0;
      e_done  = 1'b0;
      e_ovf   = 1'b0;
      e_abort = 1'b0;
    end
  endtask

  task automatic compare_outputs();
    check("ram_write_enable", CW'(ram_write_enable), CW'(e_we));
    if (e_we) begin
      check("ram_write_addr", CW'(ram_write_addr), CW'(e_addr));
      check("ram_write_data", ram_write_data, e_data);
    end
    check("s_ready", CW'(s_ready), CW'(m_open && (playback == PB_WRITE)));
    check("busy", CW'(busy), CW'(m_open));
    check("load_count", CW'(load_count), CW'(e_count));
    check("load_last_addr", CW'(load_last_addr), CW'(e_last));
    check("load_done", CW'(load_done), CW'(e_done));
    check("load_overflow", CW'(load_overflow), CW'(e_ovf));
    check("load_abort", CW'(load_abort), CW'(e_abort));
    if (ram_write_enable === 1'b1) begin
      mem[ram_write_addr] = ram_write_data;
      wr_count++;
    end
  endtask

  // Called at a falling edge: pulse load_start for one cycle.
  task automatic arm();
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
  endtask

  // Called at a falling edge: present one beat for one cycle.
  task automatic drive_beat(input logic [DW:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clock);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(posedge clock);
        model_step();
        #1;
        compare_outputs();
      end
      begin
        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_count", CW'(load_count), CW'(0));
        check("rst_last_addr", CW'(load_last_addr), CW'(7));
        check("rst_we", CW'(ram_write_enable), CW'(0));
        check("rst_s_ready", CW'(s_ready), CW'(0));
        check("rst_addr", CW'(ram_write_addr), CW'(0));
        check("rst_data", ram_write_data, CW'(0));
        reset = 1'b0;
        @(negedge clock);

        // Basic load: 5 beats back-to-back.
        wr_base = wr_count;
        arm();
        for (int i = 0; i < 5; i++) drive_beat(CW'(16 + i), (i == 4));
        @(negedge clock);
        check("basic_writes", CW'(wr_count - wr_base), CW'(5));
        for (int i = 0; i < 5; i++) check("basic_mem", mem[i], CW'(16 + i));
        check("basic_count", CW'(load_count), CW'(5));
        check("basic_last_addr", CW'(load_last_addr), CW'(4));
        check("basic_done", CW'(load_done), CW'(1));
        check("basic_s_ready", CW'(s_ready), CW'(0));

        // Exact fill: 8 beats.
        wr_base = wr_count;
        arm();
        for (int i = 0; i < 8; i++) drive_beat(CW'(32 + i), (i == 7));
        @(negedge clock);
        check("fill_writes", CW'(wr_count - wr_base), CW'(8));
        check("fill_mem0", mem[0], CW'(32));
        check("fill_mem7", mem[7], CW'(39));
        check("fill_count", CW'(load_count), CW'(8));
        check("fill_last_addr", CW'(load_last_addr), CW'(7));
        check("fill_overflow", CW'(load_overflow), CW'(0));
        check("fill_done", CW'(load_done), CW'(1));

        // Overflow: 11 beats, the last three are discarded.
        wr_base = wr_count;
        arm();
        for (int i = 0; i < 11; i++) drive_beat(CW'(48 + i), (i == 10));
        @(negedge clock);
        check("ovf_writes", CW'(wr_count - wr_base), CW'(8));
        check("ovf_mem2", mem[2], CW'(50));
        check("ovf_mem7", mem[7], CW'(55));
        check("ovf_overflow", CW'(load_overflow), CW'(1));
        check("ovf_done", CW'(load_done), CW'(1));
        check("ovf_count", CW'(load_count), CW'(8));
        check("ovf_last_addr", CW'(load_last_addr), CW'(7));

        // Backpressure: valid 1,0,1,0,1; a load_start while busy is ignored.
        wr_base = wr_count;
        arm();
        drive_beat(CW'(64), 1'b0);
        load_start = 1'b1;
        @(negedge clock);
        load_start = 1'b0;
        drive_beat(CW'(65), 1'b0);
        @(negedge clock);
        drive_beat(CW'(66), 1'b1);
        @(negedge clock);
        check("bp_writes", CW'(wr_count - wr_base), CW'(3));
        for (int i = 0; i < 3; i++) check("bp_mem", mem[i], CW'(64 + i));
        check("bp_count", CW'(load_count), CW'(3));
        check("bp_done", CW'(load_done), CW'(1));
        check("bp_busy", CW'(busy), CW'(0));

        // Abort: mode leaves write after two beats while a third is offered.
        wr_base = wr_count;
        arm();
        drive_beat(CW'(80), 1'b0);
        drive_beat(CW'(81), 1'b0);
        playback = PB_LOOP;
        s_valid  = 1'b1;
        s_data   = CW'(82);
        @(negedge clock);
        s_valid = 1'b0;
        @(negedge clock);
        check("abort_writes", CW'(wr_count - wr_base), CW'(2));
        check("abort_busy", CW'(busy), CW'(0));
        check("abort_flag", CW'(load_abort), CW'(1));
        check("abort_done", CW'(load_done), CW'(0));
        check("abort_count", CW'(load_count), CW'(2));
        // load_start outside write mode must not arm.
        arm();
        @(negedge clock);
        check("noarm_busy", CW'(busy), CW'(0));
        check("noarm_abort", CW'(load_abort), CW'(1));
        playback = PB_WRITE;
        @(negedge clock);

        // Reset in the cycle a beat is offered.
        wr_base = wr_count;
        arm();
        drive_beat(CW'(96), 1'b0);
        s_valid = 1'b1;
        s_data  = CW'(97);
        reset   = 1'b1;
        #1;
        check("mrst_we", CW'(ram_write_enable), CW'(0));
        check("mrst_count", CW'(load_count), CW'(0));
        check("mrst_last_addr", CW'(load_last_addr), CW'(7));
        check("mrst_s_ready", CW'(s_ready), CW'(0));
        check("mrst_busy", CW'(busy), CW'(0));
        check("mrst_addr", CW'(ram_write_addr), CW'(0));
        check("mrst_data", ram_write_data, CW'(0));
        check("mrst_flags", CW'({load_done, load_overflow, load_abort}), CW'(0));
        @(negedge clock);
        s_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("mrst_writes", CW'(wr_count - wr_base), CW'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
    join_any
  end

endmodule
